// File: rtl/ama_riscv_csr_pkg.sv
// Shared CSR types, addresses and clock defaults for the ama-riscv core.
// The clock frequency defaults are also used by the UART.
package ama_riscv_csr_pkg;

  localparam int unsigned CLK_FREQ_HZ_DEF  = 100_000_000;
  localparam int unsigned TIME_FREQ_HZ_DEF = 1_000_000;

  typedef logic [11:0] csr_addr_t;
  typedef logic [31:0] csr_t;
  typedef logic [63:0] csr_dw_t;

  typedef enum logic [1:0] {
    CSR_OP_NONE     = 2'd0,
    CSR_OP_ASSIGN   = 2'd1,
    CSR_OP_SET_BITS = 2'd2,
    CSR_OP_CLR_BITS = 2'd3
  } csr_op_sel_t;

  typedef struct packed {
    logic        en;
    logic        we;
    logic        ui;
    csr_op_sel_t op_sel;
  } csr_ctrl_t;

  localparam csr_addr_t CSR_TOHOST    = 12'h51E;
  localparam csr_addr_t CSR_MSCRATCH  = 12'h340;
  localparam csr_addr_t CSR_MCYCLE    = 12'hB00;
  localparam csr_addr_t CSR_MINSTRET  = 12'hB02;
  localparam csr_addr_t CSR_MCYCLEH   = 12'hB80;
  localparam csr_addr_t CSR_MINSTRETH = 12'hB82;
  localparam csr_addr_t CSR_TIME      = 12'hC01;
  localparam csr_addr_t CSR_TIMEH     = 12'hC81;

  function automatic csr_t csr_apply(input csr_op_sel_t op, input csr_t old_val,
                                     input csr_t w);
    csr_t res;
    res = old_val;
    case (op)
      CSR_OP_ASSIGN:   res = w;
      CSR_OP_SET_BITS: res = old_val | w;
      CSR_OP_CLR_BITS: res = old_val & ~w;
      default:         res = old_val;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ama_riscv_csr_cnt64.sv
// 64-bit wrapping counter with per-half write; a half write wins over the
// increment for that cycle and leaves the other half untouched.
module ama_riscv_csr_cnt64
  import ama_riscv_csr_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    inc,
  input  logic    we_lo,
  input  logic    we_hi,
  input  csr_t    wdata,
  output csr_dw_t cnt
);

  csr_dw_t cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (we_lo)      cnt_d[31:0]  = wdata;
    else if (we_hi) cnt_d[63:32] = wdata;
    else if (inc)   cnt_d        = cnt_q + 64'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/ama_riscv_csr.sv
// Machine CSR block: tohost, mscratch, mcycle, minstret and read-only time.
// Reads return the value as it was before the same-cycle write or increment.
module ama_riscv_csr
  import ama_riscv_csr_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ  = CLK_FREQ_HZ_DEF,
  parameter int unsigned TIME_FREQ_HZ = TIME_FREQ_HZ_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  csr_ctrl_t   csr_ctrl,
  input  csr_addr_t   csr_addr,
  input  logic        stage_en,
  input  logic [31:0] rs1_data,
  input  logic [4:0]  uimm,
  input  logic        inst_retired,
  output logic [31:0] rdata,
  output logic        illegal,
  output logic [31:0] tohost
);

  localparam int unsigned DIV = CLK_FREQ_HZ / TIME_FREQ_HZ;
  localparam logic [31:0] DIV_M1 = 32'(DIV - 1);

  if ((DIV < 1) || ((CLK_FREQ_HZ % TIME_FREQ_HZ) != 0)) begin : g_div_check
    $fatal(1, "CLK_FREQ_HZ must be a non-zero integer multiple of TIME_FREQ_HZ");
  end

  csr_t        tohost_q, tohost_d;
  csr_t        mscratch_q, mscratch_d;
  csr_t        rdata_q, rdata_d;
  logic        illegal_q, illegal_d;
  logic [31:0] psc_q, psc_d;

  csr_dw_t mcycle, minstret, mtime;
  logic    time_tick;
  logic    fire, wr;
  csr_t    w, old_val, new_val;
  logic    legal;
  logic    mcycle_we_lo, mcycle_we_hi, minstret_we_lo, minstret_we_hi;

  always_comb begin
    w         = csr_ctrl.ui ? {27'b0, uimm} : rs1_data;
    fire      = csr_ctrl.en & stage_en;
    wr        = fire & csr_ctrl.we & (csr_ctrl.op_sel != CSR_OP_NONE);
    time_tick = (psc_q == DIV_M1);
    psc_d     = time_tick ? '0 : psc_q + 32'd1;

    old_val = '0;
    legal   = 1'b1;
    case (csr_addr)
      CSR_TOHOST:    old_val = tohost_q;
      CSR_MSCRATCH:  old_val = mscratch_q;
      CSR_MCYCLE:    old_val = mcycle[31:0];
      CSR_MCYCLEH:   old_val = mcycle[63:32];
      CSR_MINSTRET:  old_val = minstret[31:0];
      CSR_MINSTRETH: old_val = minstret[63:32];
      CSR_TIME:      old_val = mtime[31:0];
      CSR_TIMEH:     old_val = mtime[63:32];
      default:       legal   = 1'b0;
    endcase
    new_val = csr_apply(csr_ctrl.op_sel, old_val, w);

    tohost_d       = (wr && csr_addr == CSR_TOHOST)   ? new_val : tohost_q;
    mscratch_d     = (wr && csr_addr == CSR_MSCRATCH) ? new_val : mscratch_q;
    mcycle_we_lo   = wr && (csr_addr == CSR_MCYCLE);
    mcycle_we_hi   = wr && (csr_addr == CSR_MCYCLEH);
    minstret_we_lo = wr && (csr_addr == CSR_MINSTRET);
    minstret_we_hi = wr && (csr_addr == CSR_MINSTRETH);

    // Result registers hold between accesses; illegal accesses read as zero.
    rdata_d   = fire ? old_val : rdata_q;
    illegal_d = fire ? ~legal  : illegal_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tohost_q   <= '0;
      mscratch_q <= '0;
      rdata_q    <= '0;
      illegal_q  <= 1'b0;
      psc_q      <= '0;
    end else begin
      tohost_q   <= tohost_d;
      mscratch_q <= mscratch_d;
      rdata_q    <= rdata_d;
      illegal_q  <= illegal_d;
      psc_q      <= psc_d;
    end
  end

  ama_riscv_csr_cnt64 u_mcycle (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (1'b1),
    .we_lo (mcycle_we_lo),
    .we_hi (mcycle_we_hi),
    .wdata (new_val),
    .cnt   (mcycle)
  );

  ama_riscv_csr_cnt64 u_minstret (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inst_retired),
    .we_lo (minstret_we_lo),
    .we_hi (minstret_we_hi),
    .wdata (new_val),
    .cnt   (minstret)
  );

  ama_riscv_csr_cnt64 u_mtime (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (time_tick),
    .we_lo (1'b0),
    .we_hi (1'b0),
    .wdata ('0),
    .cnt   (mtime)
  );

  assign rdata   = rdata_q;
  assign illegal = illegal_q;
  assign tohost  = tohost_q;

endmodule

// File: tb/tb_ama_riscv_csr.sv
// Directed bench for ama_riscv_csr with a 4:1 time prescaler.
module tb_ama_riscv_csr;
  import ama_riscv_csr_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  csr_ctrl_t   csr_ctrl;
  csr_addr_t   csr_addr;
  logic        stage_en;
  logic [31:0] rs1_data;
  logic [4:0]  uimm;
  logic        inst_retired;
  logic [31:0] rdata;
  logic        illegal;
  logic [31:0] tohost;

  int tests = 0;
  int fails = 0;

  ama_riscv_csr #(.CLK_FREQ_HZ(4_000_000), .TIME_FREQ_HZ(1_000_000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .csr_ctrl     (csr_ctrl),
    .csr_addr     (csr_addr),
    .stage_en     (stage_en),
    .rs1_data     (rs1_data),
    .uimm         (uimm),
    .inst_retired (inst_retired),
    .rdata        (rdata),
    .illegal      (illegal),
    .tohost       (tohost)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    csr_ctrl = '{en: 1'b0, we: 1'b0, ui: 1'b0, op_sel: CSR_OP_NONE};
    csr_addr = '0;
    stage_en = 1'b0;
    rs1_data = '0;
    uimm     = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One EXE-stage access lasting a single clock, then inputs return to idle.
  task automatic acc(input csr_op_sel_t op, input logic we, input csr_addr_t a,
                     input logic [31:0] rs1, input logic ui, input logic [4:0] u,
                     input logic se);
    csr_ctrl = '{en: 1'b1, we: we, ui: ui, op_sel: op};
    csr_addr = a;
    stage_en = se;
    rs1_data = rs1;
    uimm     = u;
    tick();
    idle_inputs();
  endtask

  task automatic rd(input csr_addr_t a);
    acc(CSR_OP_SET_BITS, 1'b0, a, 32'h0, 1'b0, 5'h0, 1'b1);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    inst_retired = 1'b0;
    idle_inputs();
    repeat (3) tick();
    check("rst_rdata", rdata, 32'h0);
    check("rst_illegal", {31'b0, illegal}, 32'h0);
    check("rst_tohost", tohost, 32'h0);

    // Released edges counted from here: mcycle == edges, mtime == edges/4.
    rst_n = 1'b1;
    repeat (10) tick();
    rd(CSR_MCYCLE);
    check("mcycle_at10", rdata, 32'd10);
    check("mcycle_at10_illegal", {31'b0, illegal}, 32'h0);
    tick();
    rd(CSR_TIME);
    check("time_at12", rdata, 32'd3);
    acc(CSR_OP_ASSIGN, 1'b1, CSR_TIME, 32'h55, 1'b0, 5'h0, 1'b1);
    check("time_wr_old", rdata, 32'd3);
    check("time_wr_illegal", {31'b0, illegal}, 32'h0);
    rd(CSR_TIME);
    check("time_after_wr", rdata, 32'd3);
    rd(CSR_TIMEH);
    check("timeh", rdata, 32'd0);

    acc(CSR_OP_ASSIGN, 1'b1, CSR_MSCRATCH, 32'h0F, 1'b0, 5'h0, 1'b1);
    check("mscratch_rw_old", rdata, 32'h0);
    acc(CSR_OP_SET_BITS, 1'b1, CSR_MSCRATCH, 32'hF0, 1'b0, 5'h0, 1'b1);
    check("mscratch_rs_old", rdata, 32'h0F);
    rd(CSR_MSCRATCH);
    check("mscratch_after_rs", rdata, 32'hFF);
    acc(CSR_OP_CLR_BITS, 1'b1, CSR_MSCRATCH, 32'hFFFF_FFFF, 1'b1, 5'h3, 1'b1);
    check("mscratch_rci_old", rdata, 32'hFF);
    rd(CSR_MSCRATCH);
    check("mscratch_after_rci", rdata, 32'hFC);

    // Low half write, then high half write (no increment), then one carry edge.
    acc(CSR_OP_ASSIGN, 1'b1, CSR_MCYCLE, 32'hFFFF_FFFF, 1'b0, 5'h0, 1'b1);
    acc(CSR_OP_ASSIGN, 1'b1, CSR_MCYCLEH, 32'h0, 1'b0, 5'h0, 1'b1);
    rd(CSR_MCYCLEH);
    check("mcycleh_before_carry", rdata, 32'h0);
    rd(CSR_MCYCLEH);
    check("mcycleh_after_carry", rdata, 32'h1);
    rd(CSR_MCYCLE);
    check("mcycle_after_carry", rdata, 32'h1);

    inst_retired = 1'b1;
    repeat (5) tick();
    rd(CSR_MINSTRET);
    check("minstret_5", rdata, 32'd5);
    inst_retired = 1'b0;
    rd(CSR_MINSTRET);
    check("minstret_6", rdata, 32'd6);
    inst_retired = 1'b1;
    acc(CSR_OP_ASSIGN, 1'b1, CSR_MINSTRET, 32'h100, 1'b0, 5'h0, 1'b1);
    check("minstret_wr_old", rdata, 32'd6);
    inst_retired = 1'b0;
    rd(CSR_MINSTRET);
    check("minstret_wr_wins", rdata, 32'h100);
    rd(CSR_MINSTRETH);
    check("minstreth", rdata, 32'h0);

    acc(CSR_OP_ASSIGN, 1'b1, 12'h7C0, 32'hDEAD, 1'b0, 5'h0, 1'b1);
    check("illegal_rdata", rdata, 32'h0);
    check("illegal_flag", {31'b0, illegal}, 32'h1);
    tick();
    check("illegal_hold", {31'b0, illegal}, 32'h1);
    rd(CSR_MSCRATCH);
    check("mscratch_untouched", rdata, 32'hFC);
    check("illegal_clear", {31'b0, illegal}, 32'h0);
    acc(CSR_OP_ASSIGN, 1'b1, CSR_MSCRATCH, 32'h1234, 1'b0, 5'h0, 1'b0);
    check("stall_rdata_hold", rdata, 32'hFC);
    rd(CSR_MSCRATCH);
    check("stall_no_write", rdata, 32'hFC);

    acc(CSR_OP_ASSIGN, 1'b1, CSR_TOHOST, 32'hAB, 1'b0, 5'h0, 1'b1);
    check("tohost_wr_old", rdata, 32'h0);
    check("tohost_next_cycle", tohost, 32'hAB);

    rst_n = 1'b0;
    acc(CSR_OP_ASSIGN, 1'b1, CSR_TOHOST, 32'h1, 1'b0, 5'h0, 1'b1);
    check("rst_mid_tohost", tohost, 32'h0);
    check("rst_mid_rdata", rdata, 32'h0);
    rst_n = 1'b1;
    rd(CSR_MCYCLE);
    check("mcycle_first_edge", rdata, 32'h0);
    rd(CSR_MCYCLE);
    check("mcycle_second_edge", rdata, 32'h1);
    check("tohost_after_rst", tohost, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
